// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB-to-register bridge and the config register block.
package apb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bridge_state_t;

    localparam int NUM_REGS_DEF = 2;
    localparam int CTRL_OFS     = 0;
    localparam int DEBUG_OFS    = 1;

    localparam int CTRL_MODE_EN_BIT   = 0;
    localparam int CTRL_DBG_EN_BIT    = 1;
    localparam int CTRL_PARITY_EN_BIT = 2;
    localparam int CTRL_EN_LSB        = 3;
    localparam int CTRL_EN_MSB        = 31;

    typedef struct packed {
        logic [CTRL_EN_MSB-CTRL_EN_LSB:0] ctrl_en;
        logic                             parity_en;
        logic                             dbg_en;
        logic                             mode_en;
    } ctrl_reg_t;

    // A single-register map still needs a one-bit select bus.
    function automatic int sel_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// Combinational address decode: alignment, range and (with APB_BRIDGE_PROT_EN) write privilege.
module apb_reg_decode
    import apb_reg_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SEL_W    = sel_width(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
`ifdef APB_BRIDGE_PROT_EN
    input  logic [2:0]        pprot,
`endif
    output logic              decode_ok,
    output logic [SEL_W-1:0]  sel
);

    logic align_ok;
    logic range_ok;
    logic prot_ok;

    assign align_ok = (paddr[1:0] == 2'b00);
    assign range_ok = ((paddr >> 2) < ADDR_W'(NUM_REGS));

`ifdef APB_BRIDGE_PROT_EN
    logic prot_unused;
    // Only the privilege bit gates writes; secure/instruction bits are ignored.
    assign prot_ok     = !(pwrite && !pprot[0]);
    assign prot_unused = ^pprot[2:1];
`else
    logic pwrite_unused;
    assign prot_ok       = 1'b1;
    assign pwrite_unused = pwrite;
`endif

    assign decode_ok = align_ok && range_ok && prot_ok;
    assign sel       = paddr[2 +: SEL_W];

endmodule

// File: rtl/apb_reg_bridge.sv
// APB3 slave driving the single-strobe register-access protocol.
// Optional macro APB_BRIDGE_PROT_EN adds pprot and rejects unprivileged writes.
module apb_reg_bridge
    import apb_reg_pkg::*;
#(
    parameter  int ADDR_W   = 12,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int WR_WAIT  = 0,
    parameter  int RD_WAIT  = 1,
    localparam int SEL_W    = sel_width(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
`ifdef APB_BRIDGE_PROT_EN
    input  logic [2:0]        pprot,
`endif
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic              reg_valid,
    output logic              reg_read_write,
    output logic [SEL_W-1:0]  reg_sel,
    output logic [31:0]       reg_wdata,
    input  logic [31:0]       reg_rdata
);

    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT);
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT);

    bridge_state_t    state_q;
    logic [3:0]       cnt_q;
    logic             pready_q;
    logic             pslverr_q;
    logic [31:0]      prdata_q;
    logic [31:0]      rdata_hold_q;
    logic             reg_valid_q;
    logic             reg_rw_q;
    logic [SEL_W-1:0] reg_sel_q;
    logic [31:0]      reg_wdata_q;

    logic             decode_ok;
    logic [SEL_W-1:0] dec_sel;
    logic [3:0]       wait_load;

    apb_reg_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_decode (
        .paddr     (paddr),
        .pwrite    (pwrite),
`ifdef APB_BRIDGE_PROT_EN
        .pprot     (pprot),
`endif
        .decode_ok (decode_ok),
        .sel       (dec_sel)
    );

    assign wait_load = reg_rw_q ? WR_LOAD : RD_LOAD;

    // Bridge FSM with all APB and register-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            prdata_q     <= 32'h0000_0000;
            rdata_hold_q <= 32'h0000_0000;
            reg_valid_q  <= 1'b0;
            reg_rw_q     <= 1'b0;
            reg_sel_q    <= '0;
            reg_wdata_q  <= 32'h0000_0000;
        end else begin
            reg_valid_q <= 1'b0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (psel && penable) begin
                        if (decode_ok) begin
                            state_q     <= DRIVE;
                            reg_valid_q <= 1'b1;
                            reg_rw_q    <= pwrite;
                            reg_sel_q   <= dec_sel;
                            reg_wdata_q <= pwdata;
                        end else begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            if (!pwrite) begin
                                prdata_q <= 32'h0000_0000;
                            end
                        end
                    end
                end
                DRIVE: begin
                    cnt_q <= wait_load;
                    if (wait_load != 4'd0) begin
                        state_q <= WAIT;
                    end else begin
                        state_q  <= RESP;
                        pready_q <= 1'b1;
                        if (!reg_rw_q) begin
                            prdata_q     <= reg_rdata;
                            rdata_hold_q <= reg_rdata;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q  <= RESP;
                        pready_q <= 1'b1;
                        if (!reg_rw_q) begin
                            prdata_q     <= reg_rdata;
                            rdata_hold_q <= reg_rdata;
                        end
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    // An error read zeroes prdata only for its own response.
                    prdata_q <= rdata_hold_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pready         = pready_q;
    assign pslverr        = pslverr_q;
    assign prdata         = prdata_q;
    assign reg_valid      = reg_valid_q;
    assign reg_read_write = reg_rw_q;
    assign reg_sel        = reg_sel_q;
    assign reg_wdata      = reg_wdata_q;

endmodule
